// File: rtl/ram_wr_buffer_ctrl.sv
// Posted-write buffer in front of a single-clock RAM; drains writes when no read is accepted and resolves read-after-write hazards.
// Optional macro RAM_WR_BUFFER_CTRL_FWD_EN forwards read hits from the buffer; without it a hitting read stalls until the hit drains.
module ram_wr_buffer_ctrl #(
    parameter int WIDTH      = 32,
    parameter int WORD_SIZE  = 8,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [WORD_SIZE-1:0]          wr_addr_in,
    input  logic [WIDTH-1:0]              wr_data_in,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic [WORD_SIZE-1:0]          rd_addr_in,
    output logic                          rsp_valid,
    output logic [WIDTH-1:0]              rsp_data,
    output logic                          ram_wr_en,
    output logic [WORD_SIZE-1:0]          ram_wr_addr,
    output logic [WIDTH-1:0]              ram_data_in,
    output logic [WORD_SIZE-1:0]          ram_rd_addr,
    input  logic [WIDTH-1:0]              ram_data_out,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WBUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WORD_SIZE-1:0] buf_addr [WBUF_DEPTH];
    logic [WIDTH-1:0]     buf_data [WBUF_DEPTH];
    logic [PTR_W-1:0]     head, tail, slot;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     stall_cnt, stall_cnt_nxt;
    logic [WORD_SIZE-1:0] last_addr;

    logic push, pop, rd_acc, rsp_fire, hit;
`ifdef RAM_WR_BUFFER_CTRL_FWD_EN
    logic [WIDTH-1:0] hit_data;
`else
    logic [PTR_W-1:0] hit_age;
`endif

    assign wr_ready   = (count != CNT_FULL);
    assign rd_ready   = (state == RUN);
    assign push       = wr_valid && wr_ready;
    assign rd_acc     = rd_valid && rd_ready;
    // An accepted read owns the cycle: the RAM never sees a write alongside a read.
    assign pop        = (count != '0) && !rd_acc && !rst;

    assign ram_wr_en   = pop;
    assign ram_wr_addr = buf_addr[head];
    assign ram_data_in = buf_data[head];
    assign ram_rd_addr = rd_acc ? rd_addr_in : last_addr;
    assign wbuf_count  = count;

    // Walk the valid entries oldest-first so the last match is the newest one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hit  = 1'b0;
        slot = head;
`ifdef RAM_WR_BUFFER_CTRL_FWD_EN
        hit_data = '0;
`else
        hit_age = '0;
`endif
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (buf_addr[slot] == rd_addr_in)) begin
                hit = 1'b1;
`ifdef RAM_WR_BUFFER_CTRL_FWD_EN
                hit_data = buf_data[slot];
`else
                hit_age = PTR_W'(i);
`endif
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        rsp_fire      = 1'b0;
        case (state)
            RUN: begin
                if (rd_acc) begin
`ifdef RAM_WR_BUFFER_CTRL_FWD_EN
                    rsp_fire = 1'b1;
`else
                    if (hit) begin
                        state_nxt     = STALL;
                        stall_cnt_nxt = CNT_W'(hit_age) + CNT_ONE;
                    end else begin
                        rsp_fire = 1'b1;
                    end
`endif
                end
            end
            STALL: begin
                // Counter at zero means every entry up to the newest hit has reached the RAM.
                if (stall_cnt == '0) begin
                    state_nxt = RUN;
                    rsp_fire  = 1'b1;
                end else if (pop) begin
                    stall_cnt_nxt = stall_cnt - CNT_ONE;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            last_addr <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
            rsp_valid <= rsp_fire;
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (rd_acc) last_addr <= rd_addr_in;
            if (rsp_fire) begin
`ifdef RAM_WR_BUFFER_CTRL_FWD_EN
                rsp_data <= (state == RUN && hit) ? hit_data : ram_data_out;
`else
                rsp_data <= ram_data_out;
`endif
            end
        end
    end

    // NOTE: the entry storage is deliberately not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= wr_addr_in;
            buf_data[tail] <= wr_data_in;
        end
    end

endmodule

// File: tb/tb_ram_wr_buffer_ctrl.sv
// Self-checking bench for ram_wr_buffer_ctrl: an in-bench RAM, a queue-based reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_ram_wr_buffer_ctrl;

    localparam int WIDTH      = 32;
    localparam int WORD_SIZE  = 8;
    localparam int WBUF_DEPTH = 4;
    localparam int CNT_W      = $clog2(WBUF_DEPTH) + 1;
`ifdef RAM_WR_BUFFER_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_valid = 1'b0;
    logic                 wr_ready;
    logic [WORD_SIZE-1:0] wr_addr_in = '0;
    logic [WIDTH-1:0]     wr_data_in = '0;
    logic                 rd_valid = 1'b0;
    logic                 rd_ready;
    logic [WORD_SIZE-1:0] rd_addr_in = '0;
    logic                 rsp_valid;
    logic [WIDTH-1:0]     rsp_data;
    logic                 ram_wr_en;
    logic [WORD_SIZE-1:0] ram_wr_addr;
    logic [WIDTH-1:0]     ram_data_in;
    logic [WORD_SIZE-1:0] ram_rd_addr;
    logic [WIDTH-1:0]     ram_data_out;
    logic [CNT_W-1:0]     wbuf_count;

    // Bench-side preload port for the RAM model.
    logic                 pre_we = 1'b0;
    logic [WORD_SIZE-1:0] pre_addr = '0;
    logic [WIDTH-1:0]     pre_data = '0;

    bit [WIDTH-1:0]       env_ram [2**WORD_SIZE];
    logic [WORD_SIZE-1:0] ram_log [$];
    logic [WIDTH-1:0]     rsp_log [$];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [WORD_SIZE-1:0] addr;
        logic [WIDTH-1:0]     data;
    } wr_t;

    wr_t mq [$];

    ram_wr_buffer_ctrl #(
        .WIDTH(WIDTH), .WORD_SIZE(WORD_SIZE), .WBUF_DEPTH(WBUF_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_in(rd_addr_in),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
        .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out),
        .wbuf_count(wbuf_count)
    );

    always #5 clk = ~clk;

    assign ram_data_out = env_ram[ram_rd_addr];

    always @(posedge clk) begin
        if (ram_wr_en) begin
            env_ram[ram_wr_addr] <= ram_data_in;
            ram_log.push_back(ram_wr_addr);
        end else if (pre_we) begin
            env_ram[pre_addr] <= pre_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as an ordered queue, RAM contents as an array.
    initial begin : model
        bit             stalled = 1'b0;
        int             pops_left = 0;
        logic [7:0]     st_addr = '0;
        logic [31:0]    st_data = '0;
        bit             exp_rv = 1'b0;
        logic [31:0]    exp_rd = '0;
        bit             last_known = 1'b0;
        logic [7:0]     last_addr = '0;
        bit [WIDTH-1:0] mmem [2**WORD_SIZE];
        int             sz, m;
        bit             acc, drn, nv;
        logic [31:0]    nd;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_wr_en", ram_wr_en, 0);
                mq.delete();
                stalled    = 1'b0;
                exp_rv     = 1'b0;
                exp_rd     = '0;
                last_known = 1'b0;
            end else begin
                sz = mq.size();
                check("wbuf_count", wbuf_count, sz);
                check("wr_ready", wr_ready, sz != WBUF_DEPTH);
                check("rd_ready", rd_ready, !stalled);
                check("rsp_valid", rsp_valid, exp_rv);
                check("rsp_data", rsp_data, exp_rd);
                if (rsp_valid) rsp_log.push_back(rsp_data);

                acc = rd_valid && !stalled;
                drn = (sz > 0) && !acc;
                check("ram_wr_en", ram_wr_en, drn);
                if (drn) begin
                    check("ram_wr_addr", ram_wr_addr, mq[0].addr);
                    check("ram_data_in", ram_data_in, mq[0].data);
                end

                nv = 1'b0;
                nd = '0;
                if (acc) begin
                    check("ram_rd_addr_acc", ram_rd_addr, rd_addr_in);
                    m = -1;
                    for (int i = 0; i < sz; i++)
                        if (mq[i].addr == rd_addr_in) m = i;
                    if (m >= 0 && !FWD) begin
                        stalled   = 1'b1;
                        pops_left = m + 1;
                        st_addr   = rd_addr_in;
                        st_data   = mq[m].data;
                    end else begin
                        nv = 1'b1;
                        if (m >= 0) nd = mq[m].data;
                        else        nd = mmem[rd_addr_in];
                    end
                    last_addr  = rd_addr_in;
                    last_known = 1'b1;
                end else begin
                    if (last_known) check("ram_rd_addr_hold", ram_rd_addr, last_addr);
                    if (stalled) begin
                        if (pops_left == 0) begin
                            check("ram_rd_addr_release", ram_rd_addr, st_addr);
                            nv      = 1'b1;
                            nd      = st_data;
                            stalled = 1'b0;
                        end else if (drn) begin
                            pops_left--;
                        end
                    end
                end

                if (drn) begin
                    mmem[mq[0].addr] = mq[0].data;
                    void'(mq.pop_front());
                end
                if (wr_valid && sz != WBUF_DEPTH) mq.push_back('{addr: wr_addr_in, data: wr_data_in});
                if (pre_we) mmem[pre_addr] = pre_data;
                exp_rv = nv;
                if (nv) exp_rd = nd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic rd_req(input logic [7:0] a);
        bit done = 1'b0;
        rd_valid   = 1'b1;
        rd_addr_in = a;
        for (int i = 0; i < 64 && !done; i++) begin
            if (rd_ready) done = 1'b1;
            tick();
        end
        rd_valid = 1'b0;
        check("rd_accept_timeout", done, 1);
    endtask

    task automatic wait_rsp(output logic [31:0] d);
        bit got = 1'b0;
        d = 'x;
        for (int i = 0; i < 64 && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                d   = rsp_data;
            end else begin
                tick();
            end
        end
        check("rsp_timeout", got, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] d;
        int          mark, rmark, wi;
        bit          wr_ok;

        repeat (2) tick();
        rst = 1'b0;
        check("reset_count", wbuf_count, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_ram_wr_en", ram_wr_en, 0);
        check("reset_rd_ready", rd_ready, 1);
        check("reset_wr_ready", wr_ready, 1);

        // Single write drains next cycle; later read sees it from the RAM.
        wr_valid = 1'b1; wr_addr_in = 8'h10; wr_data_in = 32'hDEADBEEF;
        tick();
        wr_valid = 1'b0;
        check("t1_drain_en", ram_wr_en, 1);
        check("t1_drain_addr", ram_wr_addr, 8'h10);
        tick();
        check("t1_count_empty", wbuf_count, 0);
        tick();
        rd_req(8'h10);
        wait_rsp(d);
        check("t1_rsp", d, 32'hDEADBEEF);
        idle(2);

        // Continuous reads hold off the drain until the buffer fills.
        rd_valid = 1'b1; rd_addr_in = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr_in = 8'(i); wr_data_in = 32'h100 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        check("t2_full_count", wbuf_count, 4);
        check("t2_full_wr_ready", wr_ready, 0);
        check("t2_no_drain", ram_wr_en, 0);
        mark = ram_log.size();
        rd_valid = 1'b0;
        repeat (4) tick();
        check("t2_drain_n", ram_log.size() - mark, 4);
        for (int i = 0; i < 4; i++)
            if (mark + i < ram_log.size()) check("t2_drain_order", ram_log[mark + i], i);
        check("t2_empty_count", wbuf_count, 0);
        check("t2_empty_wr_ready", wr_ready, 1);
        idle(2);

        // Two buffered writes to one address; the read must see the newer one.
        rd_valid = 1'b1; rd_addr_in = 8'hF0;
        wr_valid = 1'b1; wr_addr_in = 8'h05; wr_data_in = 32'h11;
        tick();
        wr_data_in = 32'h22;
        tick();
        wr_valid = 1'b0;
        rd_req(8'h05);
        if (!FWD) check("t3_stall_rd_ready", rd_ready, 0);
        wait_rsp(d);
        check("t3_rsp_newest", d, 32'h22);
        idle(6);

        // Read-before-write in the same cycle.
        pre_we = 1'b1; pre_addr = 8'h07; pre_data = 32'hAAAA;
        tick();
        pre_we = 1'b0;
        wr_valid = 1'b1; wr_addr_in = 8'h07; wr_data_in = 32'hBBBB;
        rd_valid = 1'b1; rd_addr_in = 8'h07;
        tick();
        wr_valid = 1'b0; rd_valid = 1'b0;
        wait_rsp(d);
        check("t4_rsp_old", d, 32'hAAAA);
        rd_req(8'h07);
        wait_rsp(d);
        check("t4_rsp_new", d, 32'hBBBB);
        idle(6);

        // Wrap-around: more writes than entries, reads on two of every three cycles.
        mark = ram_log.size();
        wi = 0;
        for (int c = 0; c < 80 && wi < WBUF_DEPTH + 3; c++) begin
            wr_valid = 1'b1; wr_addr_in = 8'h20 + 8'(wi); wr_data_in = 32'hC0DE0000 + 32'(wi);
            rd_valid = (c % 3 != 2); rd_addr_in = 8'hF1;
            wr_ok = wr_ready;
            tick();
            if (wr_ok) wi++;
        end
        wr_valid = 1'b0;
        check("t5_all_written", wi, WBUF_DEPTH + 3);
        rd_req(8'h26);
        wait_rsp(d);
        check("t5_rsp_wrapped", d, 32'hC0DE0006);
        idle(10);
        check("t5_drain_n", ram_log.size() - mark, WBUF_DEPTH + 3);
        for (int i = 0; i < WBUF_DEPTH + 3; i++)
            if (mark + i < ram_log.size()) check("t5_drain_order", ram_log[mark + i], 8'h20 + 8'(i));

        // Reset with three buffered writes (and a stalled read when not forwarding).
        rd_valid = 1'b1; rd_addr_in = 8'hF2;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr_in = 8'h30 + 8'(i); wr_data_in = 32'h300 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        rd_addr_in = 8'h32;
        tick();
        rd_valid = 1'b0;
        wr_valid = 1'b1; wr_addr_in = 8'h33; wr_data_in = 32'h303;
        tick();
        wr_valid = 1'b0;
        check("t6_pre_count", wbuf_count, 3);
        if (!FWD) check("t6_pre_stall", rd_ready, 0);
        mark  = ram_log.size();
        rmark = rsp_log.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_count", wbuf_count, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_rd_ready", rd_ready, 1);
        check("t6_wr_en", ram_wr_en, 0);
        repeat (5) tick();
        check("t6_no_writes", ram_log.size() - mark, 0);
        check("t6_no_rsp", rsp_log.size() - rmark, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
